field_sync_tracker: RTL
=======================

# field_sync_tracker

Front-end sync stage for the PAL video pad path. It samples the raw VDG horizontal and field sync strobes on the video clock and counts lines per field. It classifies each field as NTSC or PAL and drives the `Format` select and the post-field-sync pad window that the pad/clock-gating stage consumes. `Format` changes only after two consecutive fields of the same class agree.

## Interface
Parameters:
- `PAD_LINES`, 24, number of lines the pad window stays open after field sync
- `CNT_W`, 9, line counter width
- `NTSC_MIN`/`NTSC_MAX`, 256/268, inclusive field-length range classified NTSC
- `PAL_MIN`/`PAL_MAX`, 306/318, inclusive field-length range classified PAL
- `DEFAULT_FMT`, 1, `Format` value out of reset (1 = NTSC, 0 = PAL)

Ports:
- `VCLK`  in  1  video clock; the only clock
- `RST`  in  1  reset: synchronous, active-high
- `HSb`  in  1  raw horizontal sync, active low
- `FSb`  in  1  raw field sync, active low
- `Format`  out  1  detected format, 1 = NTSC, 0 = PAL
- `LINE`  out  CNT_W  lines counted since last FSb falling edge
- `PADWIN`  out  1  pad window, high for exactly `PAD_LINES` lines
- `LOCKED`  out  1  two matching consecutive fields seen
- `FS_EDGE`  out  1  one-cycle strobe per accepted FSb falling edge

## Operation
- `HSb`/`FSb` pass through 2-flop synchronisers; a falling edge is the sync-stage output going 1→0 relative to a third register.
- On an HS edge, `LINE` increments and saturates at 2^CNT_W−1.
- On an FS edge:
  - the current `LINE` is latched as field length;
  - `LINE` is cleared to 0;
  - the length is classified NTSC, PAL or INVALID.
- HS and FS edges in the same cycle: FS wins, `LINE`=0, and that HS is not counted.
- The first FS edge after reset only starts the count: that partial field is discarded and not classified.
- State machine:
  - SEARCH:
    - valid class → ACQUIRE with candidate=class;
    - INVALID → stay.
  - ACQUIRE:
    - class==candidate → LOCKED, and `Format`←class;
    - other valid class → ACQUIRE with new candidate;
    - INVALID → SEARCH.
  - LOCKED:
    - class==`Format` → stay;
    - other valid class → ACQUIRE with candidate=class;
    - INVALID → SEARCH.
  - Watchdog, any state: `LINE` reaching saturation → SEARCH.
- `LOCKED`=1 only in the LOCKED state. `Format` is held unchanged in all other states.
- Pad window:
  - The first HS edge after an FS edge loads the pad counter with `PAD_LINES` and sets `PADWIN`, provided the state is LOCKED.
  - Each later HS edge decrements the counter; the edge that reaches 0 clears `PADWIN`.
  - An FS edge clears `PADWIN` and re-arms the window.
  - Leaving LOCKED clears `PADWIN` immediately.

## Timing
- Reset values: `Format`=DEFAULT_FMT, `LINE`=0, `PADWIN`=0, `LOCKED`=0, `FS_EDGE`=0, state SEARCH, first-field flag set.
- A falling edge on a pin sampled at VCLK edge N gives an internal edge strobe at N+2. Registered outputs (`LINE`, `PADWIN`, `FS_EDGE`, `LOCKED`, `Format`) update at N+3.
- `FS_EDGE` is high for exactly one VCLK. It is also asserted for the discarded first field.
- `Format` and `LOCKED` change only in the cycle `FS_EDGE` is high, or on the watchdog cycle (`LOCKED` only).
- `RST` mid-field: all state returns to reset values on the next VCLK, and the next field is treated as the first.
- Syncs are at least 3 VCLK wide; shorter pulses may be missed and that is not an error.

## Configuration
- `FORMAT_OVERRIDE_EN` defined:
  - adds inputs `FMT_FORCE` (1 bit) and `FMT_VAL` (1 bit);
  - while `FMT_FORCE`=1, `Format`=`FMT_VAL` one VCLK later, and `LOCKED` is forced 1 so `PADWIN` runs;
  - detection continues internally;
  - when `FMT_FORCE` drops, `Format`/`LOCKED` show the internal state the next cycle.
- Undefined: the ports do not exist and `Format` is purely detected.

## Structure
- Shared package `video_pkg`:
  - state enum (SEARCH/ACQUIRE/LOCKED);
  - class enum (NTSC/PAL/INVALID);
  - format encoding constants `FMT_NTSC`=1, `FMT_PAL`=0;
  - default field-length limits.
- Sub-module `sync_edge`: 2-flop synchroniser plus falling-edge strobe, instantiated once for HSb and once for FSb.

## Test plan
- 3 fields of 312 lines after reset → first field discarded; `LOCKED`=1 and `Format`=0 at third FS_EDGE+0; `PADWIN` high for exactly 24 HS edges of the following field.
- Locked PAL, then 262-line fields → `LOCKED` drops after the first NTSC field with `Format` still 0; `Format`=1 and `LOCKED`=1 after the second.
- Locked, then one 290-line field → SEARCH, `LOCKED`=0, `PADWIN`=0, `Format` unchanged.
- HS and FS falling in the same cycle → `LINE`=0 (not 1); field length excludes that HS.
- FSb held high for 600 lines → `LINE` saturates at 511 and watchdog drives SEARCH; `RST` pulse mid-field → all outputs at reset values on the next VCLK.
- With `FORMAT_OVERRIDE_EN`, `FMT_FORCE`=1 and `FMT_VAL`=0 during NTSC input → `Format`=0 and `PADWIN` runs; release → `Format`=1 next cycle.

Source files
------------

// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared types, format codes and field-length limits for the video sync path
//
// Purpose : state and field-class enums, Format encoding and the default
//           NTSC/PAL field-length windows used by field_sync_tracker.
// Ports   : none (package).
package video_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_ACQUIRE,
    ST_LOCKED
  } state_e;

  typedef enum logic [1:0] {
    CLS_NTSC,
    CLS_PAL,
    CLS_INVALID
  } class_e;

  localparam logic FMT_NTSC = 1'b1;
  localparam logic FMT_PAL  = 1'b0;

  localparam int DEF_NTSC_MIN = 256;
  localparam int DEF_NTSC_MAX = 268;
  localparam int DEF_PAL_MIN  = 306;
  localparam int DEF_PAL_MAX  = 318;

  // Inclusive windows; anything outside both is INVALID.
  function automatic class_e classify(input int len, input int ntsc_min, input int ntsc_max,
                                      input int pal_min, input int pal_max);
    if (len >= ntsc_min && len <= ntsc_max) return CLS_NTSC;
    if (len >= pal_min && len <= pal_max) return CLS_PAL;
    return CLS_INVALID;
  endfunction

  function automatic logic class_fmt(input class_e c);
    return (c == CLS_NTSC) ? FMT_NTSC : FMT_PAL;
  endfunction

endpackage

// File: rtl/field_sync_tracker_if.sv
// rtl/field_sync_tracker_if.sv - sync strobe inputs and format/pad status outputs of the tracker
//
// Purpose : bundles the raw VDG sync strobes and the tracker's status outputs.
//           With FORMAT_OVERRIDE_EN defined, FMT_FORCE/FMT_VAL are added.
// Signals : HSb, FSb (to tracker, active low); Format, LINE[CNT_W], PADWIN,
//           LOCKED, FS_EDGE (from tracker); FMT_FORCE, FMT_VAL (optional, to tracker).
// Modports: master = sync source / status consumer, slave = the tracker.
interface field_sync_tracker_if #(
  parameter int CNT_W = 9
);
  logic             HSb;
  logic             FSb;
  logic             Format;
  logic [CNT_W-1:0] LINE;
  logic             PADWIN;
  logic             LOCKED;
  logic             FS_EDGE;
`ifdef FORMAT_OVERRIDE_EN
  logic             FMT_FORCE;
  logic             FMT_VAL;

  modport master (output HSb, FSb, FMT_FORCE, FMT_VAL,
                  input  Format, LINE, PADWIN, LOCKED, FS_EDGE);
  modport slave  (input  HSb, FSb, FMT_FORCE, FMT_VAL,
                  output Format, LINE, PADWIN, LOCKED, FS_EDGE);
`else
  modport master (output HSb, FSb,
                  input  Format, LINE, PADWIN, LOCKED, FS_EDGE);
  modport slave  (input  HSb, FSb,
                  output Format, LINE, PADWIN, LOCKED, FS_EDGE);
`endif
endinterface

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - 2-flop synchroniser with registered falling-edge strobe
//
// Purpose : brings an asynchronous active-low strobe into the clk domain and
//           emits a one-cycle pulse for each 1->0 transition.
// Ports   : clk, rst (sync, active high), din (async input), fall (strobe out).
// Latency : din low sampled at edge N -> fall high after edge N+2.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Idle level is high so reset never manufactures an edge.
      s1   <= 1'b1;
      s2   <= 1'b1;
      s3   <= 1'b1;
      fall <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s3   <= s2;
      fall <= s3 & ~s2;
    end
  end

endmodule

// File: rtl/field_sync_tracker.sv
// rtl/field_sync_tracker.sv - line counter, NTSC/PAL field classifier and pad window generator
//
// Purpose : counts HS edges per field, classifies each field by length,
//           switches Format after two agreeing fields, and opens PADWIN for
//           PAD_LINES lines after each field sync while locked.
// Ports   : VCLK (clock), RST (sync, active high), bus (field_sync_tracker_if.slave:
//           HSb/FSb in; Format, LINE, PADWIN, LOCKED, FS_EDGE out).
// Config  : FORMAT_OVERRIDE_EN adds FMT_FORCE/FMT_VAL to force Format and LOCKED.
module field_sync_tracker
  import video_pkg::*;
#(
  parameter int PAD_LINES   = 24,
  parameter int CNT_W       = 9,
  parameter int NTSC_MIN    = DEF_NTSC_MIN,
  parameter int NTSC_MAX    = DEF_NTSC_MAX,
  parameter int PAL_MIN     = DEF_PAL_MIN,
  parameter int PAL_MAX     = DEF_PAL_MAX,
  parameter int DEFAULT_FMT = 1
) (
  input logic                 VCLK,
  input logic                 RST,
  field_sync_tracker_if.slave bus
);

  localparam int               PW       = $clog2(PAD_LINES + 1);
  localparam logic [CNT_W-1:0] LINE_MAX = {CNT_W{1'b1}};

  logic hs_fall, fs_fall;

  sync_edge u_hs_sync (.clk(VCLK), .rst(RST), .din(bus.HSb), .fall(hs_fall));
  sync_edge u_fs_sync (.clk(VCLK), .rst(RST), .din(bus.FSb), .fall(fs_fall));

  state_e           state;
  class_e           cand;
  logic             fmt_q;
  logic [CNT_W-1:0] line_q;
  logic [PW-1:0]    pad_cnt;
  logic             padwin_q;
  logic             armed;      // next HS is the first of the field
  logic             first;      // next FS only starts counting
  logic             fs_edge_q;
  logic             lock_eff;   // locked as seen by the pad window and LOCKED output

  class_e           cls;
  logic [CNT_W-1:0] line_inc;

  assign cls      = classify(int'(line_q), NTSC_MIN, NTSC_MAX, PAL_MIN, PAL_MAX);
  assign line_inc = (line_q == LINE_MAX) ? line_q : line_q + CNT_W'(1);

`ifdef FORMAT_OVERRIDE_EN
  logic force_q, force_val_q;

  always_ff @(posedge VCLK) begin
    if (RST) begin
      force_q     <= 1'b0;
      force_val_q <= 1'b0;
    end else begin
      force_q     <= bus.FMT_FORCE;
      force_val_q <= bus.FMT_VAL;
    end
  end

  assign lock_eff   = force_q | (state == ST_LOCKED);
  assign bus.Format = force_q ? force_val_q : fmt_q;
`else
  assign lock_eff   = (state == ST_LOCKED);
  assign bus.Format = fmt_q;
`endif

  assign bus.LOCKED  = lock_eff;
  assign bus.LINE    = line_q;
  assign bus.PADWIN  = padwin_q;
  assign bus.FS_EDGE = fs_edge_q;

  always_ff @(posedge VCLK) begin
    if (RST) begin
      state     <= ST_SEARCH;
      cand      <= CLS_INVALID;
      fmt_q     <= 1'(DEFAULT_FMT);
      line_q    <= '0;
      pad_cnt   <= '0;
      padwin_q  <= 1'b0;
      armed     <= 1'b0;
      first     <= 1'b1;
      fs_edge_q <= 1'b0;
    end else begin
      fs_edge_q <= fs_fall;
      if (fs_fall) begin
        // FS takes priority: a coincident HS is not counted.
        line_q   <= '0;
        padwin_q <= 1'b0;
        armed    <= 1'b1;
        if (first) begin
          first <= 1'b0;
        end else begin
          case (state)
            ST_SEARCH: begin
              if (cls != CLS_INVALID) begin
                state <= ST_ACQUIRE;
                cand  <= cls;
              end
            end
            ST_ACQUIRE: begin
              if (cls == CLS_INVALID) begin
                state <= ST_SEARCH;
              end else if (cls == cand) begin
                state <= ST_LOCKED;
                fmt_q <= class_fmt(cls);
              end else begin
                cand <= cls;
              end
            end
            ST_LOCKED: begin
              if (cls == CLS_INVALID) begin
                state <= ST_SEARCH;
              end else if (class_fmt(cls) != fmt_q) begin
                state <= ST_ACQUIRE;
                cand  <= cls;
              end
            end
            default: state <= ST_SEARCH;
          endcase
        end
      end else if (hs_fall) begin
        line_q <= line_inc;
        if (line_inc == LINE_MAX) begin
          // Watchdog: no field sync for a whole counter range.
          state    <= ST_SEARCH;
          padwin_q <= 1'b0;
        end else if (armed) begin
          armed <= 1'b0;
          if (lock_eff) begin
            pad_cnt  <= PW'(PAD_LINES);
            padwin_q <= 1'b1;
          end
        end else if (padwin_q) begin
          pad_cnt <= pad_cnt - PW'(1);
          if (pad_cnt == PW'(1)) padwin_q <= 1'b0;
        end
      end
      // Covers a force release dropping the effective lock mid-window.
      if (!lock_eff) padwin_q <= 1'b0;
    end
  end

endmodule
